// File: rtl/cortical_neuron_array_tm.sv
// cortical_neuron_array_tm: time-multiplexed LIF neuron array with STP,
// adaptive threshold, dopamine modulation. Option: CORTICAL_REFRACTORY_EN.
module cortical_neuron_array_tm #(
    parameter int N_NEURON = 8,
    parameter int POT_W    = 24,
    parameter int TH_W     = 16,
    parameter int WEIGHT_W = 16,
    parameter int TH_INIT  = 2048,
    parameter int REFRAC   = 4,
    parameter int IDX_W    = $clog2(N_NEURON)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       tick_i,
    input  logic                       syn_valid_i,
    output logic                       syn_ready_o,
    input  logic [IDX_W-1:0]           syn_idx_i,
    input  logic signed [WEIGHT_W-1:0] i_syn,
    input  logic [7:0]                 dopamine_i,
    output logic                       spike_valid_o,
    output logic [IDX_W-1:0]           spike_idx_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overrun_o
);
    localparam int EW = POT_W + 2;
    localparam int TW = TH_W + 1;

    if (N_NEURON < 2) begin : g_bad_n
        $error("N_NEURON must be at least 2");
    end
    if (REFRAC < 1 || REFRAC > 255) begin : g_bad_refrac
        $error("REFRAC must be within 1..255");
    end

    typedef enum logic {IDLE, SWEEP} state_t;
    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic sweep, last, syn_take, refr, spike;
    logic spike_valid_q, done_q, overrun_q;
    logic [IDX_W-1:0] spike_idx_q;

    logic signed [POT_W-1:0]    v_all     [N_NEURON];
    logic [TH_W-1:0]            th_all    [N_NEURON];
    logic [15:0]                facil_all [N_NEURON];
    logic [15:0]                depr_all  [N_NEURON];
    logic signed [WEIGHT_W-1:0] acc_all   [N_NEURON];

    logic signed [POT_W-1:0]    v_cur, v_d, v_min, v_max;
    logic signed [EW-1:0]       v_ext, gain, sum;
    logic signed [TH_W-1:0]     v_top;
    logic [TH_W-1:0]            th_cur, th_eff, th_nxt;
    logic [TW-1:0]              th_diff;
    logic [15:0]                facil_cur, facil_nxt;
    logic [15:0]                depr_cur, depr_nxt;
    logic signed [WEIGHT_W-1:0] acc_cur, acc_in, acc_new;
    logic signed [WEIGHT_W:0]   acc_sum;

    assign sweep    = (state_q == SWEEP);
    assign last     = (idx_q == IDX_W'(N_NEURON - 1));
    assign syn_take = !sweep && syn_valid_i;

    assign syn_ready_o   = !sweep;
    assign busy_o        = sweep;
    assign spike_valid_o = spike_valid_q;
    assign spike_idx_o   = spike_idx_q;
    assign done_o        = done_q;
    assign overrun_o     = overrun_q;

`ifdef CORTICAL_REFRACTORY_EN
    logic [7:0] refrac_all [N_NEURON];
    assign refr = (refrac_all[idx_q] != 8'd0);
`else
    assign refr = 1'b0;
`endif

    // State register for the sweep sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: a tick starts a sweep that visits every neuron once
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (tick_i) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (last) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared update datapath for the neuron selected by idx_q
    always_comb begin
        v_cur     = v_all[idx_q];
        th_cur    = th_all[idx_q];
        facil_cur = facil_all[idx_q];
        depr_cur  = depr_all[idx_q];
        acc_cur   = acc_all[idx_q];
        v_min     = {1'b1, {(POT_W-1){1'b0}}};
        v_max     = {1'b0, {(POT_W-1){1'b1}}};
        v_ext     = $signed({{2{v_cur[POT_W-1]}}, v_cur});
        gain      = '0;
        if (!refr) begin
            gain = $signed({{(EW-WEIGHT_W){acc_cur[WEIGHT_W-1]}}, acc_cur});
        end
        sum = v_ext - (v_ext >>> 3) + gain
            + $signed({{(EW-8){1'b0}}, facil_cur[15:8]})
            - $signed({{(EW-8){1'b0}}, depr_cur[15:8]});
        if (&sum[EW-1:POT_W-1] || ~|sum[EW-1:POT_W-1]) begin
            v_d = sum[POT_W-1:0];
        end else if (sum[EW-1]) begin
            v_d = v_min;
        end else begin
            v_d = v_max;
        end
        v_top   = v_d[POT_W-1 -: TH_W];
        th_diff = {1'b0, th_cur} - TW'({dopamine_i, 8'h00});
        th_eff  = th_diff[TW-1] ? '0 : th_diff[TH_W-1:0];
        spike   = !refr
                && ($signed({v_top[TH_W-1], v_top}) >= $signed({1'b0, th_eff}));
        facil_nxt = facil_cur - (facil_cur >> 4);
        if (!acc_cur[WEIGHT_W-1] && |acc_cur) begin
            facil_nxt = facil_nxt + 16'd32;
        end
        th_nxt   = th_cur - (th_cur >> 5) + (spike ? TH_W'(32) : '0);
        depr_nxt = depr_cur - (depr_cur >> 4) + (spike ? 16'd64 : 16'd0);
        acc_in   = acc_all[syn_idx_i];
        acc_sum  = {acc_in[WEIGHT_W-1], acc_in} + {i_syn[WEIGHT_W-1], i_syn};
        acc_new  = acc_sum[WEIGHT_W-1:0];
        if (acc_sum[WEIGHT_W] != acc_sum[WEIGHT_W-1]) begin
            acc_new = acc_sum[WEIGHT_W]
                    ? {1'b1, {(WEIGHT_W-1){1'b0}}}
                    : {1'b0, {(WEIGHT_W-1){1'b1}}};
        end
    end

    for (genvar g = 0; g < N_NEURON; g++) begin : g_neuron
        logic signed [POT_W-1:0]    v_q;
        logic [TH_W-1:0]            th_q;
        logic [15:0]                facil_q;
        logic [15:0]                depr_q;
        logic signed [WEIGHT_W-1:0] acc_q;
        logic                       upd, hit;

        assign upd = sweep && (idx_q == IDX_W'(g));
        assign hit = syn_take && (syn_idx_i == IDX_W'(g));

        // Write-back in this neuron's sweep slot, else event accumulation
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q     <= '0;
                th_q    <= TH_W'(TH_INIT);
                facil_q <= '0;
                depr_q  <= '0;
                acc_q   <= '0;
            end else if (clk_en) begin
                if (upd) begin
                    v_q     <= spike ? '0 : v_d;
                    th_q    <= th_nxt;
                    facil_q <= facil_nxt;
                    depr_q  <= depr_nxt;
                    acc_q   <= '0;
                end else if (hit) begin
                    acc_q <= acc_new;
                end
            end
        end

        assign v_all[g]     = v_q;
        assign th_all[g]    = th_q;
        assign facil_all[g] = facil_q;
        assign depr_all[g]  = depr_q;
        assign acc_all[g]   = acc_q;

`ifdef CORTICAL_REFRACTORY_EN
        logic [7:0] refrac_q;

        // Refractory countdown, reloaded on a spike
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                refrac_q <= '0;
            end else if (clk_en && upd) begin
                if (spike) begin
                    refrac_q <= 8'(REFRAC);
                end else if (refrac_q != 8'd0) begin
                    refrac_q <= refrac_q - 8'd1;
                end
            end
        end

        assign refrac_all[g] = refrac_q;
`endif
    end

    // Registered spike/done pulses and sticky overrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (clk_en) begin
            spike_valid_q <= sweep && spike;
            if (sweep && spike) begin
                spike_idx_q <= idx_q;
            end
            done_q <= sweep && last;
            if (sweep && tick_i) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule
